// File: rtl/lfsr_seq_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// lfsr_seq_ctrl
// ----------------------------------------------------------------------------
// Sequencer for an 8-bit LFSR block. On a start request it:
//   1. pulses the LFSR scramble strobe for a programmable number of cycles,
//   2. pulses the LFSR serial-shift strobe for WIDTH cycles,
//   3. captures the LFSR serial stream (one cycle behind the shift strobe),
//      LSB first, into a parallel word,
//   4. presents the word on a valid/ready handshake.
//
// Parameters
//   WIDTH  bits captured per word (matches the LFSR register width)
//   CNT_W  width of shift_cnt and the internal scramble counter
//
// Ports
//   clk              in   clock, all logic on the rising edge
//   rst              in   asynchronous active-low reset
//   start            in   request one word (only looked at in IDLE)
//   shift_cnt        in   scramble cycles before serialising (latched on start)
//   abort            in   synchronous return to IDLE
//   lfsr_out         in   serial bit from the LFSR
//   lfsr_valid       in   LFSR serial-valid flag
//   lfsr_enable      out  LFSR scramble strobe
//   lfsr_out_enable  out  LFSR serial-shift strobe
//   busy             out  controller is not idle
//   data_out         out  assembled word
//   data_valid       out  word available
//   data_ready       in   consumer accepts the word
//   err              out  sticky: a bit was captured while lfsr_valid was low
//   word_cnt         out  completed-handshake counter (optional, see below)
//
// Build option
//   LFSR_CTRL_WORDCNT_EN  when defined, adds the 16-bit word_cnt output that
//                         counts delivered words and wraps at 16'hFFFF.
// ============================================================================
module lfsr_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
    input  logic             abort,
    input  logic             lfsr_out,
    input  logic             lfsr_valid,
    output logic             lfsr_enable,
    output logic             lfsr_out_enable,
    output logic             busy,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
`ifdef LFSR_CTRL_WORDCNT_EN
    output logic [15:0]      word_cnt,
`endif
    output logic             err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHIFT  = 3'd1;
    localparam logic [2:0] S_SERIAL = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_serIdx;

    logic [2:0]       w_nextState;
    logic [CNT_W-1:0] w_nextCnt;
    logic [IDX_W-1:0] w_nextSerIdx;
    logic             w_startAcc;
    logic             w_capture;
    logic [IDX_W-1:0] w_capIdx;
    logic             w_handshake;

    // Next-state logic. Abort overrides everything, so no capture, start
    // acceptance or handshake can happen in an aborted cycle.
    // r_cnt holds the remaining scramble cycles including the current one;
    // SHIFT is left when it reaches 1, so the full CNT_W range is usable.
    // r_serIdx counts serial-strobe cycles; the bit produced by strobe n
    // arrives one cycle later, so SERIAL cycle n captures bit n-1 and DRAIN
    // captures the final bit.
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_nextSerIdx = r_serIdx;
        w_startAcc   = 1'b0;
        w_capture    = 1'b0;
        w_capIdx     = '0;
        w_handshake  = 1'b0;
        if (abort) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_startAcc   = 1'b1;
                        w_nextCnt    = shift_cnt;
                        w_nextSerIdx = '0;
                        w_nextState  = (shift_cnt != '0) ? S_SHIFT : S_SERIAL;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_nextCnt   = '0;
                        w_nextState = S_SERIAL;
                    end else begin
                        w_nextCnt = r_cnt - CNT_W'(1);
                    end
                end
                S_SERIAL: begin
                    if (r_serIdx != '0) begin
                        w_capture = 1'b1;
                        w_capIdx  = r_serIdx - IDX_W'(1);
                    end
                    if (r_serIdx == IDX_W'(WIDTH - 1)) begin
                        w_nextSerIdx = '0;
                        w_nextState  = S_DRAIN;
                    end else begin
                        w_nextSerIdx = r_serIdx + IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    w_capture   = 1'b1;
                    w_capIdx    = IDX_W'(WIDTH - 1);
                    w_nextState = S_HOLD;
                end
                S_HOLD: begin
                    if (data_ready) begin
                        w_handshake = 1'b1;
                        w_nextState = S_IDLE;
                    end
                end
                default: begin
                    w_nextState = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and the registered strobes/status. Outputs are decoded
    // from the next state so they line up with the state they belong to
    // without any combinational path to the ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_serIdx        <= '0;
            lfsr_enable     <= 1'b0;
            lfsr_out_enable <= 1'b0;
            busy            <= 1'b0;
            data_valid      <= 1'b0;
        end else begin
            r_state         <= w_nextState;
            r_cnt           <= w_nextCnt;
            r_serIdx        <= w_nextSerIdx;
            lfsr_enable     <= (w_nextState == S_SHIFT);
            lfsr_out_enable <= (w_nextState == S_SERIAL);
            busy            <= (w_nextState != S_IDLE);
            data_valid      <= (w_nextState == S_HOLD);
        end
    end

    // Bit-wise word assembly and the sticky error flag. An invalid bit is
    // stored as 0 so a flagged word never carries stale LFSR data. data_out
    // is otherwise untouched, which keeps a partial word after an abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            if (w_capture) begin
                data_out[w_capIdx] <= lfsr_valid & lfsr_out;
            end
            if (w_startAcc) begin
                err <= 1'b0;
            end else if (w_capture && !lfsr_valid) begin
                err <= 1'b1;
            end
        end
    end

`ifdef LFSR_CTRL_WORDCNT_EN
    // Delivered-word counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= 16'd0;
        end else if (w_handshake) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`else
    // Handshake decode only feeds the optional word counter.
    logic w_unusedHandshake;
    assign w_unusedHandshake = w_handshake;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// tb_lfsr_seq_ctrl
// ----------------------------------------------------------------------------
// Directed bench for lfsr_seq_ctrl. The bench plays the LFSR: one cycle after
// each serial-shift strobe it drives the next bit of a known stream. Each
// requested word's expected value is queued when start is driven and popped
// when the handshake completes.
// ============================================================================
module tb_lfsr_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  shift_cnt;
    logic        abort;
    logic        lfsr_out;
    logic        lfsr_valid;
    logic        lfsr_enable;
    logic        lfsr_out_enable;
    logic        busy;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready;
    logic        err;
`ifdef LFSR_CTRL_WORDCNT_EN
    logic [15:0] word_cnt;
`endif

    int compareCount = 0;
    int failCount    = 0;
    int cyc          = 0;
    int wordsDone    = 0;
    logic [7:0] lastWord = 8'h00;
    logic       lastErr  = 1'b0;

    logic [7:0] expQ[$];
    logic       errQ[$];

    lfsr_seq_ctrl #(
        .WIDTH(8),
        .CNT_W(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .shift_cnt       (shift_cnt),
        .abort           (abort),
        .lfsr_out        (lfsr_out),
        .lfsr_valid      (lfsr_valid),
        .lfsr_enable     (lfsr_enable),
        .lfsr_out_enable (lfsr_out_enable),
        .busy            (busy),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
`ifdef LFSR_CTRL_WORDCNT_EN
        .word_cnt        (word_cnt),
`endif
        .err             (err)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle and settle just after the edge so outputs are
    // sampled well away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Single comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)",
                   tag, observed, expected, cyc);
        end
    endtask

    task automatic checkWordCnt(input string tag);
`ifdef LFSR_CTRL_WORDCNT_EN
        checkOutput(tag, 32'(word_cnt), 32'(wordsDone));
`else
        if (tag.len() == 0) $display("[TB] empty tag");
`endif
    endtask

    // Runs one full word: start with the given scramble count, act as the
    // LFSR for the given bit stream and valid mask, hold data_ready low for
    // holdCycles once the word is offered, then accept it.
    task automatic applyStimulus(input logic [7:0] sc, input logic [7:0] bits,
                                 input logic [7:0] vmask, input int holdCycles);
        logic [7:0] expWord;
        logic       expErr;
        logic [7:0] popWord;
        logic       popErr;
        logic       prevOutEn;
        int         idx;
        int         limit;

        expWord = bits & vmask;
        expErr  = (vmask != 8'hFF);
        expQ.push_back(expWord);
        errQ.push_back(expErr);

        checkOutput("err_before_start", 32'(err), 32'(lastErr));
        shift_cnt = sc;
        start     = 1'b1;
        cyc       = 0;
        idx       = 0;
        prevOutEn = 1'b0;
        tick();
        start     = 1'b0;
        shift_cnt = 8'hA5;
        checkOutput("err_clear_on_start", 32'(err), 32'd0);

        limit = 32'(sc) + 20;
        while (data_valid !== 1'b1 && cyc < limit) begin
            checkOutput("lfsr_enable", 32'(lfsr_enable),
                        32'(cyc >= 1 && cyc <= 32'(sc)));
            checkOutput("lfsr_out_enable", 32'(lfsr_out_enable),
                        32'(cyc > 32'(sc) && cyc <= 32'(sc) + 8));
            checkOutput("busy_running", 32'(busy), 32'd1);
            if (prevOutEn && idx < 8) begin
                lfsr_valid = vmask[idx];
                lfsr_out   = vmask[idx] ? bits[idx] : 1'b1;
                idx++;
            end else begin
                lfsr_valid = 1'b1;
                lfsr_out   = 1'b0;
            end
            prevOutEn = lfsr_out_enable;
            tick();
        end
        lfsr_valid = 1'b1;
        lfsr_out   = 1'b0;
        checkOutput("dv_latency", 32'(cyc), 32'(sc) + 10);

        data_ready = 1'b0;
        repeat (holdCycles) begin
            checkOutput("hold_valid", 32'(data_valid), 32'd1);
            checkOutput("hold_data", 32'(data_out), 32'(expQ[0]));
            checkOutput("hold_strobes", 32'({lfsr_enable, lfsr_out_enable}), 32'd0);
            tick();
        end

        data_ready = 1'b1;
        popWord = expQ.pop_front();
        popErr  = errQ.pop_front();
        checkOutput("handshake_valid", 32'(data_valid), 32'd1);
        checkOutput("data_out", 32'(data_out), 32'(popWord));
        checkOutput("err", 32'(err), 32'(popErr));
        tick();
        data_ready = 1'b0;
        wordsDone++;
        lastWord = popWord;
        lastErr  = popErr;
        checkOutput("dv_after_ready", 32'(data_valid), 32'd0);
        checkOutput("busy_after_ready", 32'(busy), 32'd0);
        checkWordCnt("word_cnt_after_word");
        tick();
        checkOutput("err_sticky", 32'(err), 32'(popErr));
        checkOutput("data_retained", 32'(data_out), 32'(popWord));
    endtask

    // Directed sequence: reset, normal words, hold, abort, invalid bits,
    // maximum scramble count, reset mid-serialisation and recovery.
    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        shift_cnt  = 8'h00;
        abort      = 1'b0;
        lfsr_out   = 1'b0;
        lfsr_valid = 1'b1;
        data_ready = 1'b0;

        tick();
        tick();
        checkOutput("reset_strobes", 32'({lfsr_enable, lfsr_out_enable}), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_dv", 32'(data_valid), 32'd0);
        checkOutput("reset_data", 32'(data_out), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkWordCnt("reset_word_cnt");
        rst = 1'b1;
        tick();

        $display("[TB] word with shift_cnt=3, stream 1,0,1,1,0,0,1,0");
        applyStimulus(8'd3, 8'h4D, 8'hFF, 0);

        $display("[TB] word with shift_cnt=0, ready held low 5 cycles");
        applyStimulus(8'd0, 8'hC3, 8'hFF, 5);

        $display("[TB] abort in third scramble cycle");
        shift_cnt = 8'd5;
        start     = 1'b1;
        cyc       = 0;
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("abort_pre_enable", 32'(lfsr_enable), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_strobes", 32'({lfsr_enable, lfsr_out_enable}), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_dv", 32'(data_valid), 32'd0);
        checkOutput("abort_data_kept", 32'(data_out), 32'(lastWord));
        checkWordCnt("abort_word_cnt");
        repeat (15) begin
            checkOutput("abort_no_dv", 32'({data_valid, busy}), 32'd0);
            tick();
        end

        $display("[TB] first captured bit invalid");
        applyStimulus(8'd1, 8'hFF, 8'hFE, 1);

        $display("[TB] maximum shift_cnt");
        applyStimulus(8'd255, 8'h5A, 8'hFF, 2);

        $display("[TB] reset during serialisation");
        shift_cnt = 8'd2;
        start     = 1'b1;
        cyc       = 0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        checkOutput("serial_before_reset", 32'(lfsr_out_enable), 32'd1);
        rst = 1'b0;
        tick();
        checkOutput("midreset_strobes", 32'({lfsr_enable, lfsr_out_enable}), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_dv", 32'(data_valid), 32'd0);
        checkOutput("midreset_data", 32'(data_out), 32'd0);
        checkOutput("midreset_err", 32'(err), 32'd0);
        wordsDone = 0;
        lastWord  = 8'h00;
        lastErr   = 1'b0;
        checkWordCnt("midreset_word_cnt");
        rst = 1'b1;
        tick();

        $display("[TB] words after reset");
        applyStimulus(8'd2, 8'h96, 8'h7F, 1);
        applyStimulus(8'd4, 8'h3C, 8'hFF, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
